// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, frame shift on
// device clocks, ACK check, and completion/error/timeout reporting.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_ack_err,
   output logic       tx_timeout,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t         state_reg;
   logic [9:0]     frame_reg;
   logic [3:0]     bit_cnt_reg;
   logic [IW-1:0]  inh_cnt_reg;
   logic [TW-1:0]  timer_reg;
   logic           ack_bad_reg;

   logic           clk_meta_reg;
   logic           clk_sync_reg;
   logic           clk_prev_reg;
   logic           data_meta_reg;
   logic           data_sync_reg;

   logic           clk_fall;
   logic           timeout_hit;

   // Both pins idle high, so the synchronizers reset to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta_reg  <= 1'b1;
         clk_sync_reg  <= 1'b1;
         clk_prev_reg  <= 1'b1;
         data_meta_reg <= 1'b1;
         data_sync_reg <= 1'b1;
      end else begin
         clk_meta_reg  <= ps2_clk_in;
         clk_sync_reg  <= clk_meta_reg;
         clk_prev_reg  <= clk_sync_reg;
         data_meta_reg <= ps2_data_in;
         data_sync_reg <= data_meta_reg;
      end
   end

   assign clk_fall    = ~clk_sync_reg & clk_prev_reg;
   assign timeout_hit = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         frame_reg   <= '0;
         bit_cnt_reg <= '0;
         inh_cnt_reg <= '0;
         timer_reg   <= '0;
         ack_bad_reg <= 1'b0;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         tx_ack_err  <= 1'b0;
         tx_timeout  <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         tx_done    <= 1'b0;
         tx_ack_err <= 1'b0;
         tx_timeout <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               if (tx_valid && tx_ready) begin
                  frame_reg   <= {1'b1, ~^tx_data, tx_data};
                  inh_cnt_reg <= '0;
                  state_reg   <= S_INHIBIT;
                  ps2_clk_oe  <= 1'b1;
                  tx_ready    <= 1'b0;
                  busy        <= 1'b1;
               end
            end

            S_INHIBIT: begin
               if (inh_cnt_reg == IW'(INHIBIT_CYCLES - 1)) begin
                  state_reg   <= S_REQ;
                  ps2_data_oe <= 1'b1;
               end else begin
                  inh_cnt_reg <= inh_cnt_reg + IW'(1);
               end
            end

            S_REQ: begin
               state_reg   <= S_SEND;
               ps2_clk_oe  <= 1'b0;
               timer_reg   <= '0;
               bit_cnt_reg <= '0;
            end

            S_SEND: begin
               if (timeout_hit) begin
                  state_reg   <= S_IDLE;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
                  busy        <= 1'b0;
                  tx_timeout  <= 1'b1;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
                  if (clk_fall) begin
                     // Edges 1..10 drive frame bits; edge 11 is the device ACK.
                     if (bit_cnt_reg == 4'd10) begin
                        ack_bad_reg <= data_sync_reg;
                        state_reg   <= S_ACK;
                     end else begin
                        ps2_data_oe <= ~frame_reg[bit_cnt_reg];
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     end
                  end
               end
            end

            S_ACK: begin
               if (timeout_hit) begin
                  state_reg   <= S_IDLE;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
                  busy        <= 1'b0;
                  tx_timeout  <= 1'b1;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
                  state_reg <= S_WAIT_IDLE;
               end
            end

            S_WAIT_IDLE: begin
               if (timeout_hit) begin
                  state_reg   <= S_IDLE;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
                  busy        <= 1'b0;
                  tx_timeout  <= 1'b1;
               end else if (clk_sync_reg && data_sync_reg) begin
                  state_reg  <= S_IDLE;
                  tx_ready   <= 1'b1;
                  busy       <= 1'b0;
                  tx_done    <= ~ack_bad_reg;
                  tx_ack_err <= ack_bad_reg;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end

            default: begin
               state_reg   <= S_IDLE;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               tx_ready    <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
